// File: rtl/row_ctrl_pkg.sv
// rtl/row_ctrl_pkg.sv - shared encodings and helpers for the multi-bank row decoder
// Contents: bank_state_e (per-bank row state), cmd_e (decoded row command),
//           decode_cmd (RAS/CAS/WE strobes to cmd_e), timer_width (bank timer width)
package row_ctrl_pkg;

    typedef enum logic [2:0] {
        BANK_IDLE,
        BANK_ACTIVATING,
        BANK_ACTIVE,
        BANK_PRECHARGING,
        BANK_REFRESHING
    } bank_state_e;

    typedef enum logic [1:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_PRE,
        CMD_REF
    } cmd_e;

    // Strobes are active low; mode set (all low) is not a row command.
    function automatic cmd_e decode_cmd(input logic ras_n, input logic cas_n, input logic we_n);
        cmd_e c;
        c = CMD_NOP;
        if (!ras_n) begin
            case ({cas_n, we_n})
                2'b11:   c = CMD_ACT;
                2'b10:   c = CMD_PRE;
                2'b01:   c = CMD_REF;
                default: c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

    // One timer per bank is reused for tRCD/tRAS, tRP and tRFC, so it must hold the largest.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/multibank_row_decoder_if.sv
// rtl/multibank_row_decoder_if.sv - row command bus from the command decoder
// Signals: RAS/CAS/WE active-low strobes, BankAddrIn target bank, RowAddrIn row for ACTIVATE
// Modports: master drives the command, slave (the row decoder) receives it
interface multibank_row_decoder_if #(
    parameter int ROW_ADDR_BITWIDTH  = 8,
    parameter int BANK_ADDR_BITWIDTH = 2
);
    logic                          RAS;
    logic                          CAS;
    logic                          WE;
    logic [BANK_ADDR_BITWIDTH-1:0] BankAddrIn;
    logic [ROW_ADDR_BITWIDTH-1:0]  RowAddrIn;

    modport master (output RAS, CAS, WE, BankAddrIn, RowAddrIn);
    modport slave  (input  RAS, CAS, WE, BankAddrIn, RowAddrIn);
endinterface

// File: rtl/bank_row_fsm.sv
// rtl/bank_row_fsm.sv - per-bank row state machine with tRCD/tRAS/tRP/tRFC timing
// Inputs:  clk, reset (async high), act/pre/refr strobes (already legality-checked),
//          row (ACTIVATE row), refresh_row (row to refresh)
// Outputs: state, tras_met, ref_done, row_en (one-hot wordline slice), open_row,
//          row_open, row_ready
module bank_row_fsm import row_ctrl_pkg::*; #(
    parameter int ROW_BITS = 8,
    parameter int T_RCD    = 2,
    parameter int T_RAS    = 4,
    parameter int T_RP     = 2,
    parameter int T_RFC    = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     act,
    input  logic                     pre,
    input  logic                     refr,
    input  logic [ROW_BITS-1:0]      row,
    input  logic [ROW_BITS-1:0]      refresh_row,
    output bank_state_e              state,
    output logic                     tras_met,
    output logic                     ref_done,
    output logic [2**ROW_BITS-1:0]   row_en,
    output logic [ROW_BITS-1:0]      open_row,
    output logic                     row_open,
    output logic                     row_ready
);
    localparam int WL = 2**ROW_BITS;
    localparam int TW = timer_width(T_RCD, T_RAS, T_RP, T_RFC);
    localparam logic [TW-1:0] RCD_T = TW'(T_RCD);
    localparam logic [TW-1:0] RAS_T = TW'(T_RAS);
    localparam logic [TW-1:0] RP_T  = TW'(T_RP);
    localparam logic [TW-1:0] RFC_T = TW'(T_RFC);
    localparam logic [TW-1:0] T_ONE = TW'(1);
    localparam logic [WL-1:0] WL_ONE = {{(WL-1){1'b0}}, 1'b1};

    bank_state_e       state_n;
    logic [TW-1:0]     timer, timer_n;
    logic [WL-1:0]     row_en_n;
    logic [ROW_BITS-1:0] open_row_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BANK_IDLE;
            timer    <= '0;
            row_en   <= '0;
            open_row <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            row_en   <= row_en_n;
            open_row <= open_row_n;
        end
    end

    // The timer holds the number of edges elapsed since the command edge, so a
    // phase of length T ends on the edge where the timer already reads T.
    always_comb begin
        state_n    = state;
        timer_n    = timer;
        row_en_n   = row_en;
        open_row_n = open_row;
        case (state)
            BANK_IDLE: begin
                if (act) begin
                    state_n    = BANK_ACTIVATING;
                    timer_n    = T_ONE;
                    row_en_n   = WL_ONE << row;
                    open_row_n = row;
                end else if (refr) begin
                    state_n  = BANK_REFRESHING;
                    timer_n  = T_ONE;
                    row_en_n = WL_ONE << refresh_row;
                end
            end
            BANK_ACTIVATING: begin
                if (timer == RCD_T) state_n = BANK_ACTIVE;
                if (timer != RAS_T) timer_n = timer + T_ONE;
            end
            BANK_ACTIVE: begin
                if (pre) begin
                    state_n    = BANK_PRECHARGING;
                    timer_n    = T_ONE;
                    row_en_n   = '0;
                    open_row_n = '0;
                end else if (timer != RAS_T) begin
                    timer_n = timer + T_ONE;
                end
            end
            BANK_PRECHARGING: begin
                if (timer == RP_T) begin
                    state_n = BANK_IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + T_ONE;
                end
            end
            BANK_REFRESHING: begin
                if (timer == RFC_T) begin
                    state_n  = BANK_IDLE;
                    timer_n  = '0;
                    row_en_n = '0;
                end else begin
                    timer_n = timer + T_ONE;
                end
            end
            default: begin
                state_n    = BANK_IDLE;
                timer_n    = '0;
                row_en_n   = '0;
                open_row_n = '0;
            end
        endcase
    end

    assign tras_met  = (timer == RAS_T);
    assign ref_done  = (state == BANK_REFRESHING) && (timer == RFC_T);
    assign row_open  = (state == BANK_ACTIVATING) || (state == BANK_ACTIVE);
    assign row_ready = (state == BANK_ACTIVE);

endmodule

// File: rtl/multibank_row_decoder.sv
// rtl/multibank_row_decoder.sv - multi-bank row decoder with timing and auto-refresh
// Inputs:  clk, reset (async high), bus (RAS/CAS/WE/BankAddrIn/RowAddrIn command)
// Outputs: RowAddrEn (one-hot wordline per bank), RowOpen, RowReady, OpenRowAddr,
//          RefreshRow (next refresh row), CmdError (one-cycle illegal-command pulse)
module multibank_row_decoder import row_ctrl_pkg::*; #(
    parameter int ROW_ADDR_BITWIDTH  = 8,
    parameter int BANK_ADDR_BITWIDTH = 2,
    parameter int T_RCD              = 2,
    parameter int T_RAS              = 4,
    parameter int T_RP               = 2,
    parameter int T_RFC              = 6
) (
    input  logic                                              clk,
    input  logic                                              reset,
    multibank_row_decoder_if.slave                            bus,
    output logic [(2**BANK_ADDR_BITWIDTH)*(2**ROW_ADDR_BITWIDTH)-1:0] RowAddrEn,
    output logic [2**BANK_ADDR_BITWIDTH-1:0]                  RowOpen,
    output logic [2**BANK_ADDR_BITWIDTH-1:0]                  RowReady,
    output logic [(2**BANK_ADDR_BITWIDTH)*ROW_ADDR_BITWIDTH-1:0] OpenRowAddr,
    output logic [ROW_ADDR_BITWIDTH-1:0]                      RefreshRow,
    output logic                                              CmdError
);
    localparam int NB = 2**BANK_ADDR_BITWIDTH;
    localparam int RB = ROW_ADDR_BITWIDTH;
    localparam int WL = 2**ROW_ADDR_BITWIDTH;

    cmd_e        cmd_dec;
    bank_state_e bank_state [NB];
    logic [NB-1:0] tras_met;
    logic [NB-1:0] ref_done;
    logic [NB-1:0] act_stb;
    logic [NB-1:0] pre_stb;
    logic          ref_stb;
    logic          err_n;
    logic          all_idle;

    assign cmd_dec = decode_cmd(bus.RAS, bus.CAS, bus.WE);

    // Only legal commands reach the banks; everything illegal becomes an error pulse.
    always_comb begin
        act_stb  = '0;
        pre_stb  = '0;
        ref_stb  = 1'b0;
        err_n    = 1'b0;
        all_idle = 1'b1;
        for (int b = 0; b < NB; b++) begin
            if (bank_state[b] != BANK_IDLE) all_idle = 1'b0;
        end
        case (cmd_dec)
            CMD_ACT: begin
                if (bank_state[bus.BankAddrIn] == BANK_IDLE) act_stb[bus.BankAddrIn] = 1'b1;
                else                                         err_n = 1'b1;
            end
            CMD_PRE: begin
                case (bank_state[bus.BankAddrIn])
                    BANK_ACTIVE: begin
                        if (tras_met[bus.BankAddrIn]) pre_stb[bus.BankAddrIn] = 1'b1;
                        else                          err_n = 1'b1;
                    end
                    BANK_ACTIVATING, BANK_REFRESHING: err_n = 1'b1;
                    default: ;
                endcase
            end
            CMD_REF: begin
                if (all_idle) ref_stb = 1'b1;
                else          err_n = 1'b1;
            end
            default: ;
        endcase
    end

    // All banks refresh in lockstep, so any bank's done flag marks the end of a refresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            CmdError   <= 1'b0;
            RefreshRow <= '0;
        end else begin
            CmdError <= err_n;
            if (|ref_done) RefreshRow <= RefreshRow + 1'b1;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        bank_row_fsm #(
            .ROW_BITS (RB),
            .T_RCD    (T_RCD),
            .T_RAS    (T_RAS),
            .T_RP     (T_RP),
            .T_RFC    (T_RFC)
        ) u_fsm (
            .clk         (clk),
            .reset       (reset),
            .act         (act_stb[b]),
            .pre         (pre_stb[b]),
            .refr        (ref_stb),
            .row         (bus.RowAddrIn),
            .refresh_row (RefreshRow),
            .state       (bank_state[b]),
            .tras_met    (tras_met[b]),
            .ref_done    (ref_done[b]),
            .row_en      (RowAddrEn[b*WL +: WL]),
            .open_row    (OpenRowAddr[b*RB +: RB]),
            .row_open    (RowOpen[b]),
            .row_ready   (RowReady[b])
        );
    end

endmodule

// File: tb/tb_multibank_row_decoder.sv
// tb/tb_multibank_row_decoder.sv - self-checking bench for multibank_row_decoder
module tb_multibank_row_decoder;
    localparam int RB = 8;
    localparam int BB = 2;
    localparam int NB = 4;
    localparam int WL = 256;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_PRE = 3'd2;
    localparam logic [2:0] C_REF = 3'd3;
    localparam logic [2:0] C_MRS = 3'd4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multibank_row_decoder_if #(.ROW_ADDR_BITWIDTH(RB), .BANK_ADDR_BITWIDTH(BB)) bus ();

    logic [NB*WL-1:0] RowAddrEn;
    logic [NB-1:0]    RowOpen;
    logic [NB-1:0]    RowReady;
    logic [NB*RB-1:0] OpenRowAddr;
    logic [RB-1:0]    RefreshRow;
    logic             CmdError;

    multibank_row_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .RowAddrEn   (RowAddrEn),
        .RowOpen     (RowOpen),
        .RowReady    (RowReady),
        .OpenRowAddr (OpenRowAddr),
        .RefreshRow  (RefreshRow),
        .CmdError    (CmdError)
    );

    typedef struct {
        logic [2:0] cmd;
        logic [1:0] bank;
        logic [7:0] row;
        int         cb;
        logic       won;
        logic [7:0] wrow;
        logic [7:0] orow;
        logic [3:0] open;
        logic [3:0] ready;
        logic       err;
        logic [7:0] rr;
    } vec_t;

    localparam int NV = 35;
    vec_t tv [NV];
    int total = 0;
    int bad = 0;
    logic [WL-1:0] one_wl;
    logic [WL-1:0] exp_wl;

    function automatic vec_t mk(input logic [2:0] c, input logic [1:0] b, input logic [7:0] r,
                                input int cb, input logic won, input logic [7:0] wrow,
                                input logic [7:0] orow, input logic [3:0] op, input logic [3:0] rd,
                                input logic er, input logic [7:0] rr);
        vec_t v;
        v.cmd = c; v.bank = b; v.row = r; v.cb = cb; v.won = won; v.wrow = wrow;
        v.orow = orow; v.open = op; v.ready = rd; v.err = er; v.rr = rr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [WL-1:0] act, input logic [WL-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_cmd(input logic [2:0] c, input logic [1:0] b, input logic [7:0] r);
        case (c)
            C_ACT:   begin bus.RAS = 1'b0; bus.CAS = 1'b1; bus.WE = 1'b1; end
            C_PRE:   begin bus.RAS = 1'b0; bus.CAS = 1'b1; bus.WE = 1'b0; end
            C_REF:   begin bus.RAS = 1'b0; bus.CAS = 1'b0; bus.WE = 1'b1; end
            C_MRS:   begin bus.RAS = 1'b0; bus.CAS = 1'b0; bus.WE = 1'b0; end
            default: begin bus.RAS = 1'b1; bus.CAS = 1'b1; bus.WE = 1'b1; end
        endcase
        bus.BankAddrIn = b;
        bus.RowAddrIn  = r;
    endtask

    // Present a command for exactly one rising edge, then sample just after it.
    task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [7:0] r);
        @(negedge clk);
        set_cmd(c, b, r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        one_wl = 1;
        tv[0]  = mk(C_ACT, 2, 8'h3C, 2, 1, 8'h3C, 8'h3C, 4'b0100, 4'b0000, 0, 0);
        tv[1]  = mk(C_NOP, 0, 8'h00, 2, 1, 8'h3C, 8'h3C, 4'b0100, 4'b0000, 0, 0);
        tv[2]  = mk(C_NOP, 0, 8'h00, 2, 1, 8'h3C, 8'h3C, 4'b0100, 4'b0100, 0, 0);
        tv[3]  = mk(C_MRS, 2, 8'h00, 2, 1, 8'h3C, 8'h3C, 4'b0100, 4'b0100, 0, 0);
        tv[4]  = mk(C_PRE, 2, 8'h00, 2, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0);
        tv[5]  = mk(C_NOP, 0, 8'h00, 2, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0);
        tv[6]  = mk(C_ACT, 2, 8'h10, 2, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 0);
        tv[7]  = mk(C_ACT, 2, 8'h10, 2, 1, 8'h10, 8'h10, 4'b0100, 4'b0000, 0, 0);
        tv[8]  = mk(C_ACT, 1, 8'h22, 1, 1, 8'h22, 8'h22, 4'b0110, 4'b0000, 0, 0);
        tv[9]  = mk(C_NOP, 0, 8'h00, 1, 1, 8'h22, 8'h22, 4'b0110, 4'b0100, 0, 0);
        tv[10] = mk(C_NOP, 0, 8'h00, 1, 1, 8'h22, 8'h22, 4'b0110, 4'b0110, 0, 0);
        tv[11] = mk(C_PRE, 1, 8'h00, 1, 1, 8'h22, 8'h22, 4'b0110, 4'b0110, 1, 0);
        tv[12] = mk(C_PRE, 1, 8'h00, 1, 0, 8'h00, 8'h00, 4'b0100, 4'b0100, 0, 0);
        tv[13] = mk(C_ACT, 0, 8'h01, 0, 1, 8'h01, 8'h01, 4'b0101, 4'b0100, 0, 0);
        tv[14] = mk(C_ACT, 0, 8'h02, 0, 1, 8'h01, 8'h01, 4'b0101, 4'b0100, 1, 0);
        tv[15] = mk(C_NOP, 0, 8'h00, 0, 1, 8'h01, 8'h01, 4'b0101, 4'b0101, 0, 0);
        tv[16] = mk(C_PRE, 3, 8'h00, 3, 0, 8'h00, 8'h00, 4'b0101, 4'b0101, 0, 0);
        tv[17] = mk(C_REF, 0, 8'h00, 0, 1, 8'h01, 8'h01, 4'b0101, 4'b0101, 1, 0);
        tv[18] = mk(C_PRE, 0, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0100, 4'b0100, 0, 0);
        tv[19] = mk(C_PRE, 2, 8'h00, 2, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0);
        tv[20] = mk(C_PRE, 2, 8'h00, 2, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0);
        tv[21] = mk(C_REF, 0, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 0);
        tv[22] = mk(C_REF, 0, 8'h00, 1, 1, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0);
        tv[23] = mk(C_NOP, 0, 8'h00, 3, 1, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0);
        tv[24] = mk(C_ACT, 0, 8'h07, 0, 1, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 0);
        tv[25] = mk(C_NOP, 0, 8'h00, 2, 1, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0);
        tv[26] = mk(C_PRE, 1, 8'h00, 1, 1, 8'h00, 8'h00, 4'b0000, 4'b0000, 1, 0);
        tv[27] = mk(C_NOP, 0, 8'h00, 0, 1, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0);
        tv[28] = mk(C_NOP, 0, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 1);
        tv[29] = mk(C_ACT, 0, 8'hAA, 0, 1, 8'hAA, 8'hAA, 4'b0001, 4'b0000, 0, 1);
        tv[30] = mk(C_ACT, 1, 8'h55, 1, 1, 8'h55, 8'h55, 4'b0011, 4'b0000, 0, 1);
        tv[31] = mk(C_NOP, 0, 8'h00, 1, 1, 8'h55, 8'h55, 4'b0011, 4'b0001, 0, 1);
        tv[32] = mk(C_NOP, 0, 8'h00, 1, 1, 8'h55, 8'h55, 4'b0011, 4'b0011, 0, 1);
        tv[33] = mk(C_PRE, 0, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0010, 4'b0010, 0, 1);
        tv[34] = mk(C_NOP, 0, 8'h00, 1, 1, 8'h55, 8'h55, 4'b0010, 4'b0010, 0, 1);

        // Reset state
        set_cmd(C_NOP, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst wl", WL'(|RowAddrEn), '0);
        chk("rst open", WL'(RowOpen), '0);
        chk("rst ready", WL'(RowReady), '0);
        chk("rst orow", WL'(OpenRowAddr), '0);
        chk("rst rr", WL'(RefreshRow), '0);
        chk("rst err", WL'(CmdError), '0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of an activate aborts it immediately
        drive(C_ACT, 0, 8'd5);
        chk("mid act open", WL'(RowOpen), WL'(4'b0001));
        chk("mid act wl", RowAddrEn[0 +: WL], one_wl << 5);
        @(negedge clk);
        set_cmd(C_NOP, 0, 0);
        reset = 1'b1;
        #1;
        chk("async wl", WL'(|RowAddrEn), '0);
        chk("async open", WL'(RowOpen), '0);
        chk("async orow", WL'(OpenRowAddr), '0);
        chk("async err", WL'(CmdError), '0);
        @(posedge clk);
        #1;
        chk("held open", WL'(RowOpen), '0);
        chk("held ready", WL'(RowReady), '0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven single-cycle sequence
        for (int i = 0; i < NV; i++) begin
            drive(tv[i].cmd, tv[i].bank, tv[i].row);
            exp_wl = tv[i].won ? (one_wl << tv[i].wrow) : '0;
            chk($sformatf("v%0d open", i), WL'(RowOpen), WL'(tv[i].open));
            chk($sformatf("v%0d ready", i), WL'(RowReady), WL'(tv[i].ready));
            chk($sformatf("v%0d err", i), WL'(CmdError), WL'(tv[i].err));
            chk($sformatf("v%0d wl b%0d", i, tv[i].cb), RowAddrEn[tv[i].cb*WL +: WL], exp_wl);
            chk($sformatf("v%0d orow b%0d", i, tv[i].cb), WL'(OpenRowAddr[tv[i].cb*RB +: RB]), WL'(tv[i].orow));
            chk($sformatf("v%0d rr", i), WL'(RefreshRow), WL'(tv[i].rr));
        end

        // Close bank1, then run refreshes until RefreshRow wraps
        drive(C_PRE, 1, 0);
        chk("pre b1 open", WL'(RowOpen), '0);
        drive(C_NOP, 0, 0);
        drive(C_NOP, 0, 0);
        for (int k = 0; k < 255; k++) begin
            drive(C_REF, 0, 0);
            chk($sformatf("ref%0d err", k), WL'(CmdError), '0);
            if (k == 0) begin
                for (int b = 0; b < NB; b++)
                    chk($sformatf("ref0 wl b%0d", b), RowAddrEn[b*WL +: WL], one_wl << 1);
                chk("ref0 open", WL'(RowOpen), '0);
            end
            repeat (6) drive(C_NOP, 0, 0);
            if (k == 127) chk("rr mid", WL'(RefreshRow), WL'(8'd129));
        end
        chk("rr wrap", WL'(RefreshRow), '0);
        chk("post ref wl", WL'(|RowAddrEn), '0);
        chk("post ref open", WL'(RowOpen), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multibank_row_decoder.md
Name: multibank_row_decoder

Overview:
Multi-bank successor to the single-bank row decoder in the SDRAM model. It decodes RAS/CAS/WE row commands per bank and drives a one-hot wordline enable per bank. It tracks open/ready state per bank with tRCD/tRAS/tRP timing and performs auto-refresh from an internal row counter. It sits between the command decoder and the per-bank cell arrays; column logic consumes RowReady.

Parameters:
ROW_ADDR_BITWIDTH, 8, row address width; wordlines per bank = 2**ROW_ADDR_BITWIDTH
BANK_ADDR_BITWIDTH, 2, bank address width; NUM_BANKS = 2**BANK_ADDR_BITWIDTH
T_RCD, 2, cycles from ACTIVATE to RowReady (min 1)
T_RAS, 4, min cycles from ACTIVATE to accepted PRECHARGE (T_RAS >= T_RCD)
T_RP, 2, cycles from PRECHARGE to IDLE (min 1)
T_RFC, 6, cycles a REFRESH holds all banks (min 1)

Ports:
clk  input  1  clock, all state changes on posedge
reset  input  1  asynchronous, active-high
RAS  input  1  row address strobe, active low
CAS  input  1  column address strobe, active low
WE  input  1  write enable, active low
BankAddrIn  input  BANK_ADDR_BITWIDTH  target bank
RowAddrIn  input  ROW_ADDR_BITWIDTH  row address for ACTIVATE
RowAddrEn  output  NUM_BANKS*2**ROW_ADDR_BITWIDTH  one-hot wordline per bank; bank b occupies slice [b*2**ROW_ADDR_BITWIDTH +: 2**ROW_ADDR_BITWIDTH]
RowOpen  output  NUM_BANKS  bank in ACTIVATING or ACTIVE
RowReady  output  NUM_BANKS  bank in ACTIVE (tRCD met)
OpenRowAddr  output  NUM_BANKS*ROW_ADDR_BITWIDTH  latched row per bank; 0 when not open
RefreshRow  output  ROW_ADDR_BITWIDTH  next row to refresh
CmdError  output  1  one-cycle pulse on illegal command

Behaviour:
- Reset (async, immediate): all banks IDLE; RowAddrEn, RowOpen, RowReady, OpenRowAddr, RefreshRow, CmdError all 0; timers 0. Reset mid-operation aborts any activate, precharge or refresh.
- Command decode is sampled on posedge:
  - RAS=0, CAS=1, WE=1: ACTIVATE.
  - RAS=0, CAS=1, WE=0: PRECHARGE (bank).
  - RAS=0, CAS=0, WE=1: REFRESH.
  - RAS=0, CAS=0, WE=0 (mode set), or RAS=1: NOP for this block.
- Per-bank states: IDLE, ACTIVATING, ACTIVE, PRECHARGING, REFRESHING. Only one command per cycle, so no simultaneous commands arise.
- ACTIVATE at edge N, bank IDLE:
  - At N: bank -> ACTIVATING; its RowAddrEn slice = one-hot(RowAddrIn); OpenRowAddr latched; RowOpen=1.
  - At N+T_RCD: -> ACTIVE, RowReady=1.
  - tRAS timer starts at N and saturates at T_RAS.
- ACTIVATE to a non-IDLE bank: illegal. CmdError=1 at N+1 cycle only; no state change.
- PRECHARGE:
  - ACTIVE bank with tRAS met: at edge M, RowAddrEn slice=0, RowOpen=0, RowReady=0, OpenRowAddr=0, -> PRECHARGING; -> IDLE at M+T_RP.
  - To an IDLE or PRECHARGING bank: legal NOP, no error.
  - To ACTIVATING, to ACTIVE with tRAS unmet, or to REFRESHING: CmdError, no change.
- REFRESH: legal only when all banks IDLE, else CmdError.
  - At edge R: all banks -> REFRESHING; every bank slice = one-hot(RefreshRow); RowOpen/RowReady stay 0.
  - At R+T_RFC: all slices 0, banks IDLE, RefreshRow increments, wrapping 2**ROW_ADDR_BITWIDTH-1 -> 0.
- Banks are independent: ACTIVATE to bank 1 while bank 0 is PRECHARGING is legal.
- Timer width: clog2(max(T_RCD, T_RAS, T_RP, T_RFC)+1).
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package row_ctrl_pkg: bank state encoding, command encodings (CMD_NOP, CMD_ACT, CMD_PRE, CMD_REF), timer width function.
- Sub-module bank_row_fsm, one instance per bank (generate loop). It owns state, timers, wordline slice and OpenRowAddr, with inputs act/pre/ref strobes and row.
- The top level owns command decode, the refresh counter, legality checks, and the CmdError register.

Test Plan:
- Reset mid-ACTIVATE: assert reset 1 cycle after ACT bank0 row 5 -> all outputs 0 immediately, bank0 IDLE, no CmdError.
- ACT bank2 row 0x3C at edge N -> bank2 slice bit 60 set at N, RowOpen[2]=1, RowReady[2]=1 at N+2; PRE at N+4 -> slice 0, IDLE at N+6.
- Early PRE: ACT bank1 at N, PRE bank1 at N+3 -> CmdError pulse, bank1 stays open; PRE at N+4 accepted.
- Double ACT bank0 (row 1 then row 2) -> second raises CmdError, OpenRowAddr[0] stays 1.
- REFRESH with bank3 open -> CmdError; after precharge, REFRESH -> all four slices bit 0 for 6 cycles, RefreshRow 0->1; 256 refreshes -> RefreshRow wraps to 0.
- Interleave: ACT bank0, ACT bank1 next cycle, PRE bank0 at tRAS -> bank1 unaffected, RowReady[1] on schedule.
